cpu6502_top: RTL and testbench
==============================

# cpu6502_top

Self-contained 6502-subset system: one multi-cycle CPU core plus a unified memory sub-block holding 512 bytes of RAM and 4 KiB of ROM. It is the top of the regression environment. A bench preloads ROM, releases reset, runs a fixed number of clocks and checks RAM contents. The core implements loads, stores, the four shift/rotate instructions, carry control and absolute jump.

## Interface
- No parameters; sizes fixed in the package.
- `ph1`  in  1  sole clock; all state updates on its rising edge.
- `resetb`  in  1  synchronous, active-high reset (1 = reset, sampled on `ph1` rising edge).
- No other ports. The bench observes and initialises state hierarchically: memory instance `mem` with arrays `ROM[0:4095]` and `RAM[0:511]`.

## Operation
- Memory map:
  - RAM at $0000–$01FF, index = addr[8:0].
  - ROM at $F000–$FFFF, index = addr[11:0]; ROM is read-only.
  - Other addresses read $00; writes to them are ignored.
- Registers:
  - A, X, Y, 8 bits each, reset to $00.
  - PC, 16 bits, reset to $0000.
  - Flags N, Z, C, reset to 0.
- Reset vector: after reset deasserts, the core reads $FFFC (PCL) then $FFFD (PCH), then fetches the first opcode from that PC. ROM[4092]=$00 and ROM[4093]=$F0 start execution at $F000.
- Opcodes:
  - LDA A9/A5/AD; LDX A2/A6/AE; LDY A0/A4/AC (immediate, zero-page, absolute). Set N and Z.
  - STA 85/8D; STX 86/8E; STY 84/8C. Flags unchanged.
  - ASL 0A/06/0E; LSR 4A/46/4E; ROL 2A/26/2E; ROR 6A/66/6E (accumulator, zero-page, absolute).
  - CLC 18, SEC 38, NOP EA, JMP abs 4C.
  - Any other opcode executes as a 2-cycle NOP.
- Shift rules:
  - ASL: C←bit7, result = v<<1.
  - LSR: C←bit0, result = v>>1, so N=0.
  - ROL: result = {v[6:0], C}, C←bit7.
  - ROR: result = {C, v[7:1]}, C←bit0.
  - Z = (result==0), N = result[7].
- Absolute operands are little-endian. Zero-page addresses are $00xx.

## Timing
- Exactly one memory access per clock. Reads are combinational from the address bus. Writes commit on the `ph1` edge.
- State machine: RESET → VEC_LO → VEC_HI → FETCH → DEC → (ADDR_HI) → (READ) → (MODIFY) → (WRITE) → FETCH.
- Cycle counts, including fetch:
  - Immediate, accumulator and implied: 2.
  - Zero-page load/store: 3. Absolute load/store: 4.
  - Zero-page read-modify-write: 5. Absolute read-modify-write: 6.
  - JMP: 3.
- RMW instructions write back the original value in the MODIFY cycle, then the result in the WRITE cycle, as on the 6502.
- Reset asserted in any cycle, including mid-instruction or mid-write: on that edge all registers return to reset values, no memory write occurs, and the state machine goes to RESET. Memory contents are preserved.
- The PC wraps from $FFFF to $0000.

## Configuration
- `ZP_INDEXED_EN` defined: adds zero-page,X addressing, with the address wrapping within page zero:
  - LDA B5, STA 95, ASL 16, LSR 56, ROL 36, ROR 76.
  - Cycle counts: load/store 4, RMW 6.
  - Adds TAX AA (sets N and Z).
- Undefined: those opcodes execute as 2-cycle NOPs.

## Structure
- Package `cpu6502_pkg` holds:
  - memory-size and base-address constants;
  - vector address $FFFC;
  - the state enum;
  - opcode localparams.
- Sub-module `cpu6502_mem` is instantiated as `mem`, with arrays `ROM` and `RAM`, a combinational read and a synchronous write.
- The core's datapath and FSM live in the top module.

## Test plan
- Reset vector: ROM[4092]=$00, ROM[4093]=$F0, program `4C 00 F0` at $F000 → PC cycles $F000–$F002; no RAM writes.
- ROL accumulator: `18 A9 37 2A 8D DD 01` → RAM[$1DD]=$6E, C=0, N=0, Z=0, within 220 clocks of reset release.
- ASL then LSR: `A9 81 0A` → A=$02, C=1. Then `4A` → A=$01, C=0, N=0.
- ROR zero-page with carry: RAM[$10]=$01, `38 66 10` → RAM[$10]=$80, C=1, N=1. The WRITE cycle lands 5 clocks after the opcode fetch.
- Zero result: `A9 80 0A` → A=$00, Z=1, C=1. Then `2A` → A=$01, Z=0, C=0.
- Mid-instruction reset: assert `resetb` during the WRITE cycle of `0E DD 01` → RAM[$1DD] unchanged; after release the vector is refetched.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared sizes, addresses, FSM states, opcodes and decode helpers
// for the 6502-subset system. Optional macro: ZP_INDEXED_EN (zero-page,X + TAX).
package cpu6502_pkg;

  localparam int          RAM_SIZE = 512;
  localparam int          ROM_SIZE = 4096;
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] ROM_BASE = 16'hF000;
  localparam logic [15:0] VEC_ADDR = 16'hFFFC;

  typedef enum logic [3:0] {
    S_RESET, S_VEC_LO, S_VEC_HI, S_FETCH, S_DEC,
    S_ADDR_HI, S_READ, S_MODIFY, S_WRITE
  } state_e;

  typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ABS, M_ZPX} mode_e;

  typedef enum logic [3:0] {
    K_NOP, K_LDA, K_LDX, K_LDY, K_STA, K_STX, K_STY,
    K_ASL, K_LSR, K_ROL, K_ROR, K_CLC, K_SEC, K_JMP, K_TAX
  } kind_e;

  typedef struct packed {
    kind_e kind;
    mode_e mode;
  } decode_t;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDA_ZP = 8'hA5, OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2, OP_LDX_ZP = 8'hA6, OP_LDX_ABS = 8'hAE;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0, OP_LDY_ZP = 8'hA4, OP_LDY_ABS = 8'hAC;
  localparam logic [7:0] OP_STA_ZP  = 8'h85, OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_STX_ZP  = 8'h86, OP_STX_ABS = 8'h8E;
  localparam logic [7:0] OP_STY_ZP  = 8'h84, OP_STY_ABS = 8'h8C;
  localparam logic [7:0] OP_ASL_ACC = 8'h0A, OP_ASL_ZP = 8'h06, OP_ASL_ABS = 8'h0E;
  localparam logic [7:0] OP_LSR_ACC = 8'h4A, OP_LSR_ZP = 8'h46, OP_LSR_ABS = 8'h4E;
  localparam logic [7:0] OP_ROL_ACC = 8'h2A, OP_ROL_ZP = 8'h26, OP_ROL_ABS = 8'h2E;
  localparam logic [7:0] OP_ROR_ACC = 8'h6A, OP_ROR_ZP = 8'h66, OP_ROR_ABS = 8'h6E;
  localparam logic [7:0] OP_CLC = 8'h18, OP_SEC = 8'h38, OP_NOP = 8'hEA, OP_JMP_ABS = 8'h4C;
`ifdef ZP_INDEXED_EN
  localparam logic [7:0] OP_LDA_ZPX = 8'hB5, OP_STA_ZPX = 8'h95;
  localparam logic [7:0] OP_ASL_ZPX = 8'h16, OP_LSR_ZPX = 8'h56;
  localparam logic [7:0] OP_ROL_ZPX = 8'h36, OP_ROR_ZPX = 8'h76;
  localparam logic [7:0] OP_TAX = 8'hAA;
`endif

  function automatic decode_t mk(input kind_e k, input mode_e m);
    decode_t d;
    d.kind = k;
    d.mode = m;
    return d;
  endfunction

  // Unlisted opcodes fall through to a one-byte implied NOP.
  function automatic decode_t decode(input logic [7:0] op);
    decode_t d;
    d = mk(K_NOP, M_IMP);
    case (op)
      OP_LDA_IMM: d = mk(K_LDA, M_IMM);
      OP_LDA_ZP:  d = mk(K_LDA, M_ZP);
      OP_LDA_ABS: d = mk(K_LDA, M_ABS);
      OP_LDX_IMM: d = mk(K_LDX, M_IMM);
      OP_LDX_ZP:  d = mk(K_LDX, M_ZP);
      OP_LDX_ABS: d = mk(K_LDX, M_ABS);
      OP_LDY_IMM: d = mk(K_LDY, M_IMM);
      OP_LDY_ZP:  d = mk(K_LDY, M_ZP);
      OP_LDY_ABS: d = mk(K_LDY, M_ABS);
      OP_STA_ZP:  d = mk(K_STA, M_ZP);
      OP_STA_ABS: d = mk(K_STA, M_ABS);
      OP_STX_ZP:  d = mk(K_STX, M_ZP);
      OP_STX_ABS: d = mk(K_STX, M_ABS);
      OP_STY_ZP:  d = mk(K_STY, M_ZP);
      OP_STY_ABS: d = mk(K_STY, M_ABS);
      OP_ASL_ACC: d = mk(K_ASL, M_IMP);
      OP_ASL_ZP:  d = mk(K_ASL, M_ZP);
      OP_ASL_ABS: d = mk(K_ASL, M_ABS);
      OP_LSR_ACC: d = mk(K_LSR, M_IMP);
      OP_LSR_ZP:  d = mk(K_LSR, M_ZP);
      OP_LSR_ABS: d = mk(K_LSR, M_ABS);
      OP_ROL_ACC: d = mk(K_ROL, M_IMP);
      OP_ROL_ZP:  d = mk(K_ROL, M_ZP);
      OP_ROL_ABS: d = mk(K_ROL, M_ABS);
      OP_ROR_ACC: d = mk(K_ROR, M_IMP);
      OP_ROR_ZP:  d = mk(K_ROR, M_ZP);
      OP_ROR_ABS: d = mk(K_ROR, M_ABS);
      OP_CLC:     d = mk(K_CLC, M_IMP);
      OP_SEC:     d = mk(K_SEC, M_IMP);
      OP_NOP:     d = mk(K_NOP, M_IMP);
      OP_JMP_ABS: d = mk(K_JMP, M_ABS);
`ifdef ZP_INDEXED_EN
      OP_LDA_ZPX: d = mk(K_LDA, M_ZPX);
      OP_STA_ZPX: d = mk(K_STA, M_ZPX);
      OP_ASL_ZPX: d = mk(K_ASL, M_ZPX);
      OP_LSR_ZPX: d = mk(K_LSR, M_ZPX);
      OP_ROL_ZPX: d = mk(K_ROL, M_ZPX);
      OP_ROR_ZPX: d = mk(K_ROR, M_ZPX);
      OP_TAX:     d = mk(K_TAX, M_IMP);
`endif
      default: d = mk(K_NOP, M_IMP);
    endcase
    return d;
  endfunction

  // Returns {carry_out, result} for the four shift/rotate kinds.
  function automatic logic [8:0] shift_op(input kind_e k, input logic [7:0] v, input logic c);
    logic [8:0] r;
    case (k)
      K_ASL:   r = {v[7], v[6:0], 1'b0};
      K_LSR:   r = {v[0], 1'b0, v[7:1]};
      K_ROL:   r = {v[7], v[6:0], c};
      K_ROR:   r = {v[0], c, v[7:1]};
      default: r = {c, v};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu6502_mem.sv
// cpu6502_mem: 512 B RAM at $0000 and 4 KiB ROM at $F000, combinational read,
// synchronous RAM write. ROM is loaded externally. Macro ZP_INDEXED_EN not used here.
module cpu6502_mem
  import cpu6502_pkg::*;
(
  input  logic        i_clk,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);

  logic [7:0] ROM [0:ROM_SIZE-1];
  logic [7:0] RAM [0:RAM_SIZE-1];

  logic w_ram_sel;
  logic w_rom_sel;

  assign w_ram_sel = (i_addr[15:9] == RAM_BASE[15:9]);
  assign w_rom_sel = (i_addr[15:12] == ROM_BASE[15:12]);

  // Decode the address and return the selected byte; unmapped space reads zero.
  always_comb begin
    o_rdata = 8'h00;
    if (w_ram_sel) begin
      o_rdata = RAM[i_addr[8:0]];
    end else if (w_rom_sel) begin
      o_rdata = ROM[i_addr[11:0]];
    end
  end

  // Only RAM accepts writes; ROM and unmapped writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_we && w_ram_sel) begin
      RAM[i_addr[8:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/cpu6502_top.sv
// cpu6502_top: multi-cycle 6502-subset core plus unified memory instance 'mem'.
// Optional macro: ZP_INDEXED_EN adds zero-page,X addressing and TAX.
module cpu6502_top
  import cpu6502_pkg::*;
(
  input logic ph1,
  input logic resetb
);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_addr;
  logic [7:0]  r_a, r_x, r_y;
  logic [7:0]  r_opcode;
  logic [7:0]  r_data;
  logic        r_n, r_z, r_c;

  decode_t     w_dec;
  logic        w_store;
  logic        w_shift;
  logic        w_rmw;
  logic        w_load;
  logic [7:0]  w_store_val;
  logic [8:0]  w_shres;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic        w_we;
  logic        w_mem_we;

  assign w_dec   = decode(r_opcode);
  assign w_store = (w_dec.kind == K_STA) || (w_dec.kind == K_STX) || (w_dec.kind == K_STY);
  assign w_shift = (w_dec.kind == K_ASL) || (w_dec.kind == K_LSR) ||
                   (w_dec.kind == K_ROL) || (w_dec.kind == K_ROR);
  assign w_rmw   = w_shift && (w_dec.mode != M_IMP);
  assign w_load  = ((r_state == S_DEC) && (w_dec.mode == M_IMM)) ||
                   ((r_state == S_READ) && !w_rmw);
  assign w_shres = shift_op(w_dec.kind, (r_state == S_MODIFY) ? r_data : r_a, r_c);

  // A write already on the bus must not land if reset is asserted on that edge.
  assign w_mem_we = w_we && !resetb;

  cpu6502_mem mem (
    .i_clk   (ph1),
    .i_addr  (w_addr),
    .i_we    (w_mem_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // Pick the register a store instruction sends to memory.
  always_comb begin
    w_store_val = r_a;
    case (w_dec.kind)
      K_STX:   w_store_val = r_x;
      K_STY:   w_store_val = r_y;
      default: w_store_val = r_a;
    endcase
  end

  // Drive the single memory access of the current cycle.
  always_comb begin
    w_addr  = r_pc;
    w_we    = 1'b0;
    w_wdata = w_store ? w_store_val : r_data;
    case (r_state)
      S_VEC_LO:  w_addr = VEC_ADDR;
      S_VEC_HI:  w_addr = VEC_ADDR + 16'd1;
      S_ADDR_HI: if (w_dec.mode == M_ZPX) w_addr = r_addr;
      S_READ:    w_addr = r_addr;
      S_MODIFY: begin
        w_addr = r_addr;
        w_we   = 1'b1;
      end
      S_WRITE: begin
        w_addr = r_addr;
        w_we   = 1'b1;
      end
      default: w_addr = r_pc;
    endcase
  end

  // Sequence the instruction phases from the decoded addressing mode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_VEC_LO;
      S_VEC_LO: w_next = S_VEC_HI;
      S_VEC_HI: w_next = S_FETCH;
      S_FETCH:  w_next = S_DEC;
      S_DEC: begin
        case (w_dec.mode)
          M_ZP:    w_next = w_store ? S_WRITE : S_READ;
          M_ABS:   w_next = S_ADDR_HI;
          M_ZPX:   w_next = S_ADDR_HI;
          default: w_next = S_FETCH;
        endcase
      end
      S_ADDR_HI: begin
        if (w_dec.kind == K_JMP) w_next = S_FETCH;
        else if (w_store)        w_next = S_WRITE;
        else                     w_next = S_READ;
      end
      S_READ:   w_next = w_rmw ? S_MODIFY : S_FETCH;
      S_MODIFY: w_next = S_WRITE;
      S_WRITE:  w_next = S_FETCH;
      default:  w_next = S_RESET;
    endcase
  end

  // State register; reset always restarts from the vector fetch.
  always_ff @(posedge ph1) begin
    if (resetb) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  // Datapath: registers, flags, PC and effective address per phase.
  always_ff @(posedge ph1) begin
    if (resetb) begin
      r_pc     <= 16'h0000;
      r_addr   <= 16'h0000;
      r_a      <= 8'h00;
      r_x      <= 8'h00;
      r_y      <= 8'h00;
      r_opcode <= 8'h00;
      r_data   <= 8'h00;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      case (r_state)
        S_VEC_LO: r_pc[7:0]  <= w_rdata;
        S_VEC_HI: r_pc[15:8] <= w_rdata;
        S_FETCH: begin
          r_opcode <= w_rdata;
          r_pc     <= r_pc + 16'd1;
        end
        S_DEC: begin
          if (w_dec.mode != M_IMP) begin
            r_pc   <= r_pc + 16'd1;
            r_addr <= {8'h00, w_rdata};
          end else if (w_shift) begin
            r_a <= w_shres[7:0];
            r_c <= w_shres[8];
            r_n <= w_shres[7];
            r_z <= (w_shres[7:0] == 8'h00);
          end else begin
            case (w_dec.kind)
              K_CLC: r_c <= 1'b0;
              K_SEC: r_c <= 1'b1;
              K_TAX: begin
                r_x <= r_a;
                r_n <= r_a[7];
                r_z <= (r_a == 8'h00);
              end
              default: ;
            endcase
          end
        end
        S_ADDR_HI: begin
          if (w_dec.mode == M_ZPX) begin
            r_addr[7:0] <= r_addr[7:0] + r_x;
          end else if (w_dec.kind == K_JMP) begin
            r_pc <= {w_rdata, r_addr[7:0]};
          end else begin
            r_addr[15:8] <= w_rdata;
            r_pc         <= r_pc + 16'd1;
          end
        end
        S_READ: if (w_rmw) r_data <= w_rdata;
        S_MODIFY: begin
          r_data <= w_shres[7:0];
          r_c    <= w_shres[8];
          r_n    <= w_shres[7];
          r_z    <= (w_shres[7:0] == 8'h00);
        end
        default: ;
      endcase
      if (w_load) begin
        case (w_dec.kind)
          K_LDA:   r_a <= w_rdata;
          K_LDX:   r_x <= w_rdata;
          K_LDY:   r_y <= w_rdata;
          default: ;
        endcase
        r_n <= w_rdata[7];
        r_z <= (w_rdata == 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_cpu6502_top.sv
// tb_cpu6502_top: directed and randomized program checks for cpu6502_top,
// compared against an instruction-level model of the 6502 subset.
module tb_cpu6502_top;

  logic ph1    = 1'b0;
  logic resetb = 1'b1;

  int nChecks = 0;
  int nErrors = 0;

  logic [7:0] prog [$];

  logic [7:0] mRam [0:511];
  logic [7:0] mA, mX, mY;
  logic       mC, mN, mZ;
  int         mCycles;

  cpu6502_top dut (
    .ph1    (ph1),
    .resetb (resetb)
  );

  // Free-running clock.
  always #5 ph1 = ~ph1;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ph1);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset, load ROM with prog at $F000 and the vector, then release.
  task automatic applyStimulus(input logic [15:0] vec);
    resetb = 1'b1;
    tick(2);
    for (int i = 0; i < 4096; i++) dut.mem.ROM[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) dut.mem.ROM[i] = prog[i];
    dut.mem.ROM[4092] = vec[7:0];
    dut.mem.ROM[4093] = vec[15:8];
    resetb = 1'b0;
  endtask

  task automatic emit(input logic [7:0] b);
    prog.push_back(b);
  endtask

  // Instruction-level shift: 0=ASL 1=LSR 2=ROL 3=ROR.
  task automatic modelShift(input int kind, input logic [7:0] v, output logic [7:0] r);
    int iv, oc, res;
    iv = int'(v);
    oc = mC ? 1 : 0;
    case (kind)
      0: begin res = (iv * 2) % 256;            mC = (iv >= 128); end
      1: begin res = iv / 2;                    mC = (iv % 2 == 1); end
      2: begin res = (iv * 2) % 256 + oc;       mC = (iv >= 128); end
      default: begin res = iv / 2 + oc * 128;  mC = (iv % 2 == 1); end
    endcase
    r  = 8'(res);
    mN = (res >= 128);
    mZ = (res == 0);
  endtask

  task automatic modelLoad(input logic [7:0] v, output logic [7:0] r);
    r  = v;
    mN = (int'(v) >= 128);
    mZ = (v == 8'h00);
  endtask

  initial begin
    logic [7:0] snap [0:511];
    logic       pcOk;
    int         diffs;
    logic [15:0] jmpAddr;

    $display("[TB] start");

    // Reset values.
    resetb = 1'b1;
    tick(2);
    checkOutput("rstA", dut.r_a, 16'h0);
    checkOutput("rstX", dut.r_x, 16'h0);
    checkOutput("rstY", dut.r_y, 16'h0);
    checkOutput("rstPC", dut.r_pc, 16'h0);
    checkOutput("rstN", dut.r_n, 16'h0);
    checkOutput("rstZ", dut.r_z, 16'h0);
    checkOutput("rstC", dut.r_c, 16'h0);

    // Reset vector then tight JMP loop; RAM must stay untouched.
    for (int i = 0; i < 512; i++) begin
      snap[i] = 8'($urandom_range(0, 255));
      dut.mem.RAM[i] = snap[i];
    end
    prog.delete();
    emit(8'h4C); emit(8'h00); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(3);
    checkOutput("vecPC", dut.r_pc, 16'hF000);
    pcOk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (dut.r_pc < 16'hF000 || dut.r_pc > 16'hF002) pcOk = 1'b0;
    end
    checkOutput("vecLoopPC", 16'(pcOk), 16'h1);
    diffs = 0;
    for (int i = 0; i < 512; i++) if (dut.mem.RAM[i] !== snap[i]) diffs++;
    checkOutput("vecNoWrite", 16'(diffs), 16'h0);

    // CLC; LDA #$37; ROL A; STA $01DD.
    dut.mem.RAM[9'h1DD] = 8'h00;
    prog.delete();
    emit(8'h18); emit(8'hA9); emit(8'h37); emit(8'h2A);
    emit(8'h8D); emit(8'hDD); emit(8'h01);
    emit(8'h4C); emit(8'h07); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(220);
    checkOutput("rolRam", dut.mem.RAM[9'h1DD], 16'h6E);
    checkOutput("rolC", dut.r_c, 16'h0);
    checkOutput("rolN", dut.r_n, 16'h0);
    checkOutput("rolZ", dut.r_z, 16'h0);

    // LDA #$81; ASL A; LSR A.
    prog.delete();
    emit(8'hA9); emit(8'h81); emit(8'h0A); emit(8'h4A);
    emit(8'h4C); emit(8'h04); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(7);
    checkOutput("aslA", dut.r_a, 16'h02);
    checkOutput("aslC", dut.r_c, 16'h1);
    tick(2);
    checkOutput("lsrA", dut.r_a, 16'h01);
    checkOutput("lsrC", dut.r_c, 16'h0);
    checkOutput("lsrN", dut.r_n, 16'h0);

    // SEC; ROR $10 with exact write timing.
    dut.mem.RAM[9'h010] = 8'h01;
    prog.delete();
    emit(8'h38); emit(8'h66); emit(8'h10);
    emit(8'h4C); emit(8'h03); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(9);
    checkOutput("rorBeforeWrite", dut.mem.RAM[9'h010], 16'h01);
    tick(1);
    checkOutput("rorRam", dut.mem.RAM[9'h010], 16'h80);
    checkOutput("rorC", dut.r_c, 16'h1);
    checkOutput("rorN", dut.r_n, 16'h1);

    // LDA #$80; ASL A -> zero; ROL A picks the carry back up.
    prog.delete();
    emit(8'hA9); emit(8'h80); emit(8'h0A); emit(8'h2A);
    emit(8'h4C); emit(8'h04); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(7);
    checkOutput("zeroA", dut.r_a, 16'h00);
    checkOutput("zeroZ", dut.r_z, 16'h1);
    checkOutput("zeroC", dut.r_c, 16'h1);
    tick(2);
    checkOutput("rol1A", dut.r_a, 16'h01);
    checkOutput("rol1Z", dut.r_z, 16'h0);
    checkOutput("rol1C", dut.r_c, 16'h0);

    // LDA #$55; ASL $01DD with reset during the WRITE cycle.
    dut.mem.RAM[9'h1DD] = 8'h41;
    prog.delete();
    emit(8'hA9); emit(8'h55); emit(8'h0E); emit(8'hDD); emit(8'h01);
    while (prog.size() < 16) emit(8'hEA);
    emit(8'h4C); emit(8'h10); emit(8'hF0);
    applyStimulus(16'hF000);
    tick(10);
    resetb = 1'b1;
    tick(1);
    checkOutput("midRstRam", dut.mem.RAM[9'h1DD], 16'h41);
    checkOutput("midRstA", dut.r_a, 16'h00);
    checkOutput("midRstPC", dut.r_pc, 16'h0000);
    dut.mem.ROM[4092] = 8'h10;
    resetb = 1'b0;
    tick(3);
    checkOutput("midRstVec", dut.r_pc, 16'hF010);
    tick(20);
    checkOutput("midRstRamLater", dut.mem.RAM[9'h1DD], 16'h41);

    // Randomized programs against the instruction-level model.
    for (int round = 0; round < 3; round++) begin
      logic [7:0] v, zp, r;
      logic [15:0] ab;
      int sel;
      for (int i = 0; i < 16; i++) begin
        mRam[9'h040 + i] = 8'($urandom_range(0, 255));
        mRam[9'h180 + i] = 8'($urandom_range(0, 255));
        dut.mem.RAM[9'h040 + i] = mRam[9'h040 + i];
        dut.mem.RAM[9'h180 + i] = mRam[9'h180 + i];
      end
      mA = 8'h00; mX = 8'h00; mY = 8'h00;
      mC = 1'b0; mN = 1'b0; mZ = 1'b0;
      mCycles = 0;
      prog.delete();
      for (int k = 0; k < 24; k++) begin
        sel = int'($urandom_range(0, 12));
        v   = 8'($urandom_range(0, 255));
        zp  = 8'(8'h40 + $urandom_range(0, 15));
        ab  = 16'(16'h0180 + $urandom_range(0, 15));
        case (sel)
          0:  begin emit(8'hA9); emit(v); modelLoad(v, mA); mCycles += 2; end
          1:  begin emit(8'hA2); emit(v); modelLoad(v, mX); mCycles += 2; end
          2:  begin emit(8'hA0); emit(v); modelLoad(v, mY); mCycles += 2; end
          3:  begin emit(8'h85); emit(zp); mRam[9'(zp)] = mA; mCycles += 3; end
          4:  begin emit(8'h8E); emit(ab[7:0]); emit(ab[15:8]); mRam[ab[8:0]] = mX; mCycles += 4; end
          5:  begin emit(8'h84); emit(zp); mRam[9'(zp)] = mY; mCycles += 3; end
          6:  begin emit(8'h0A); modelShift(0, mA, r); mA = r; mCycles += 2; end
          7:  begin emit(8'h2A); modelShift(2, mA, r); mA = r; mCycles += 2; end
          8:  begin emit(8'h46); emit(zp); modelShift(1, mRam[9'(zp)], r); mRam[9'(zp)] = r; mCycles += 5; end
          9:  begin emit(8'h6E); emit(ab[7:0]); emit(ab[15:8]); modelShift(3, mRam[ab[8:0]], r); mRam[ab[8:0]] = r; mCycles += 6; end
          10: begin emit(8'hA5); emit(zp); modelLoad(mRam[9'(zp)], mA); mCycles += 3; end
          11: begin emit(8'hAE); emit(ab[7:0]); emit(ab[15:8]); modelLoad(mRam[ab[8:0]], mX); mCycles += 4; end
          default: begin
            if (v[0]) begin emit(8'h38); mC = 1'b1; end
            else      begin emit(8'h18); mC = 1'b0; end
            mCycles += 2;
          end
        endcase
      end
      jmpAddr = 16'hF000 + 16'(prog.size());
      emit(8'h4C); emit(jmpAddr[7:0]); emit(jmpAddr[15:8]);
      applyStimulus(16'hF000);
      tick(3 + mCycles);
      checkOutput($sformatf("rnd%0d_pcAtEnd", round), dut.r_pc, jmpAddr);
      tick(6);
      checkOutput($sformatf("rnd%0d_A", round), dut.r_a, 16'(mA));
      checkOutput($sformatf("rnd%0d_X", round), dut.r_x, 16'(mX));
      checkOutput($sformatf("rnd%0d_Y", round), dut.r_y, 16'(mY));
      checkOutput($sformatf("rnd%0d_C", round), dut.r_c, 16'(mC));
      checkOutput($sformatf("rnd%0d_N", round), dut.r_n, 16'(mN));
      checkOutput($sformatf("rnd%0d_Z", round), dut.r_z, 16'(mZ));
      for (int i = 0; i < 16; i++) begin
        checkOutput($sformatf("rnd%0d_zp%0h", round, 8'h40 + i),
                    dut.mem.RAM[9'h040 + i], 16'(mRam[9'h040 + i]));
        checkOutput($sformatf("rnd%0d_abs%0h", round, 16'h0180 + i),
                    dut.mem.RAM[9'h180 + i], 16'(mRam[9'h180 + i]));
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
